// File: rtl/psum_accum_gen.sv
// Partial-sum accumulator: address-sequenced read-modify-write into a psum buffer with write forwarding.
// Latency: write issued MEM_DELAY+2 cycles after accept; no backpressure. Optional macro PSUM_ACCUM_SAT_EN saturates lane adds.
module psum_accum_gen #(
  parameter int NUM_KERNEL = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DELAY  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [CNT_WIDTH-1:0]             i_conf_outputsize,
  input  logic [CNT_WIDTH-1:0]             i_conf_passes,
  input  logic [CNT_WIDTH-1:0]             i_conf_groups,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  i_psum_dat,
  input  logic                             i_psum_vld,
  output logic [ADDR_WIDTH-1:0]            o_mem_radd,
  output logic                             o_mem_rden,
  input  logic [NUM_KERNEL*ACC_WIDTH-1:0]  i_mem_rdat,
  output logic [ADDR_WIDTH-1:0]            o_mem_wadd,
  output logic                             o_mem_wren,
  output logic [NUM_KERNEL*ACC_WIDTH-1:0]  o_mem_wdat,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int LW = NUM_KERNEL * BIT_WIDTH;
  localparam int DW = NUM_KERNEL * ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]  cfg_size, cfg_passes, cfg_groups;
  logic [CNT_WIDTH-1:0]  addr_cnt, pass_cnt, grp_cnt;
  logic [ADDR_WIDTH-1:0] base_addr, acc_addr;
  logic                  accept, addr_last, pass_last, grp_last, job_last, done_set;

  // Stage 0 lines up with the read request, stage MEM_DELAY with the returning read data.
  logic                  p_vld  [0:MEM_DELAY];
  logic                  p_init [0:MEM_DELAY];
  logic                  p_last [0:MEM_DELAY];
  logic [ADDR_WIDTH-1:0] p_addr [0:MEM_DELAY];
  logic [LW-1:0]         p_psum [0:MEM_DELAY];

  // Entry 0 is the write currently on the memory port.
  logic                  h_vld  [0:MEM_DELAY];
  logic [ADDR_WIDTH-1:0] h_addr [0:MEM_DELAY];
  logic [DW-1:0]         h_dat  [0:MEM_DELAY];
  logic                  w_last;

  logic [DW-1:0] fwd_dat, wdat_nxt;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [BIT_WIDTH-1:0] v);
    logic signed [BIT_WIDTH-1:0] s;
    s = v;
    return ACC_WIDTH'(s);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] lane_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
`ifdef PSUM_ACCUM_SAT_EN
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
    return s[ACC_WIDTH-1:0];
  endfunction

  assign accept    = (state == S_RUN) && i_psum_vld && !i_start;
  assign addr_last = (addr_cnt == cfg_size - 1'b1);
  assign pass_last = (pass_cnt == cfg_passes - 1'b1);
  assign grp_last  = (grp_cnt == cfg_groups - 1'b1);
  assign job_last  = addr_last && pass_last && grp_last;
  assign acc_addr  = base_addr + ADDR_WIDTH'(addr_cnt);
  assign done_set  = (state == S_DRAIN) && o_mem_wren && w_last;
  assign o_busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_start) state_nxt = S_RUN;
    else begin
      case (state)
        S_RUN:   if (accept && job_last) state_nxt = S_DRAIN;
        S_DRAIN: if (done_set) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_done     <= 1'b0;
      cfg_size   <= CNT_WIDTH'(1);
      cfg_passes <= CNT_WIDTH'(1);
      cfg_groups <= CNT_WIDTH'(1);
      addr_cnt   <= '0;
      pass_cnt   <= '0;
      grp_cnt    <= '0;
      base_addr  <= '0;
    end else if (i_start) begin
      o_done     <= 1'b0;
      cfg_size   <= (i_conf_outputsize == '0) ? CNT_WIDTH'(1) : i_conf_outputsize;
      cfg_passes <= (i_conf_passes == '0) ? CNT_WIDTH'(1) : i_conf_passes;
      cfg_groups <= (i_conf_groups == '0) ? CNT_WIDTH'(1) : i_conf_groups;
      addr_cnt   <= '0;
      pass_cnt   <= '0;
      grp_cnt    <= '0;
      base_addr  <= '0;
    end else begin
      if (done_set) o_done <= 1'b1;
      if (accept) begin
        if (!addr_last) addr_cnt <= addr_cnt + 1'b1;
        else begin
          addr_cnt <= '0;
          if (!pass_last) pass_cnt <= pass_cnt + 1'b1;
          else begin
            pass_cnt  <= '0;
            grp_cnt   <= grp_last ? '0 : grp_cnt + 1'b1;
            base_addr <= base_addr + ADDR_WIDTH'(cfg_size);
          end
        end
      end
    end
  end

  // Youngest matching write wins, so scan oldest to youngest.
  always_comb begin
    fwd_dat = i_mem_rdat;
    for (int i = MEM_DELAY; i >= 0; i--)
      if (h_vld[i] && (h_addr[i] == p_addr[MEM_DELAY])) fwd_dat = h_dat[i];
  end

  always_comb begin
    wdat_nxt = '0;
    for (int k = 0; k < NUM_KERNEL; k++)
      wdat_nxt[k*ACC_WIDTH +: ACC_WIDTH] = p_init[MEM_DELAY]
          ? sext(p_psum[MEM_DELAY][k*BIT_WIDTH +: BIT_WIDTH])
          : lane_add(fwd_dat[k*ACC_WIDTH +: ACC_WIDTH],
                     sext(p_psum[MEM_DELAY][k*BIT_WIDTH +: BIT_WIDTH]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_rden <= 1'b0;
      o_mem_radd <= '0;
      w_last     <= 1'b0;
      for (int i = 0; i <= MEM_DELAY; i++) begin
        p_vld[i]  <= 1'b0;
        p_init[i] <= 1'b0;
        p_last[i] <= 1'b0;
        p_addr[i] <= '0;
        p_psum[i] <= '0;
        h_vld[i]  <= 1'b0;
        h_addr[i] <= '0;
        h_dat[i]  <= '0;
      end
    end else begin
      o_mem_rden <= accept && (pass_cnt != '0);
      if (accept) o_mem_radd <= acc_addr;
      p_vld[0]  <= accept;
      p_init[0] <= (pass_cnt == '0);
      p_last[0] <= accept && job_last;
      p_addr[0] <= acc_addr;
      p_psum[0] <= i_psum_dat;
      h_vld[0]  <= p_vld[MEM_DELAY];
      h_addr[0] <= p_addr[MEM_DELAY];
      h_dat[0]  <= wdat_nxt;
      // A restart must not let the old job's final write raise done for the new job.
      w_last    <= p_last[MEM_DELAY] && !i_start;
      for (int i = 1; i <= MEM_DELAY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_init[i] <= p_init[i-1];
        p_last[i] <= p_last[i-1] && !i_start;
        p_addr[i] <= p_addr[i-1];
        p_psum[i] <= p_psum[i-1];
        h_vld[i]  <= h_vld[i-1];
        h_addr[i] <= h_addr[i-1];
        h_dat[i]  <= h_dat[i-1];
      end
    end
  end

  assign o_mem_wren = h_vld[0];
  assign o_mem_wadd = h_addr[0];
  assign o_mem_wdat = h_dat[0];

endmodule
